ps2_scancode_receiver: RTL and testbench

PS/2 keyboard receiver between the board's `PS2_CLK`/`PS2_DATA` pins and the MiniAlu `KEY` instruction path. Synchronizes and deglitches the keyboard lines and deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Folds `E0`/`F0` prefixes into a decoded scan event. Holds the most recently pressed key code as a stable 8-bit value the CPU can read at any time.

---
 rtl/ps2_scancode_receiver.sv | 144 ++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw lines, deframes
// 11-bit frames and folds E0/F0 prefixes into decoded make/break scan events.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] oScanCode,
  output logic       oScanValid,
  output logic       oBreak,
  output logic       oExtended,
  output logic [7:0] oKeyCode,
  output logic       oParityError
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;

  logic [1:0]            clkSync, dataSync;
  logic [FILTER_LEN-1:0] filtReg;
  logic                  filtClk, fall, psData;
  stateT                 state, stateNext;
  logic [2:0]            bitCnt;
  logic [7:0]            shiftReg;
  logic                  parityBit;
  logic [CNT_W-1:0]      idleCnt;
  logic                  timeout, frameDone, frameGood;
  logic                  extPend, brkPend;

  assign psData = dataSync[1];

  // Lines idle high, so the sync and filter chains reset to ones.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      filtReg  <= '1;
      filtClk  <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clkSync  <= {clkSync[0], PS2_CLK};
      dataSync <= {dataSync[0], PS2_DATA};
      filtReg  <= {filtReg[FILTER_LEN-2:0], clkSync[1]};
      fall     <= 1'b0;
      if (&filtReg) begin
        filtClk <= 1'b1;
      end else if (~|filtReg) begin
        filtClk <= 1'b0;
        fall    <= filtClk;
      end
    end
  end

  assign timeout   = (idleCnt == CNT_W'(TIMEOUT)) && (state != IDLE);
  assign frameGood = psData && (^{shiftReg, parityBit});

  always_comb begin
    stateNext = state;
    frameDone = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!psData) stateNext = DATA;
        DATA:    if (bitCnt == 3'd7) stateNext = PARITY;
        PARITY:  stateNext = STOP;
        STOP: begin
          stateNext = IDLE;
          frameDone = 1'b1;
        end
        default: stateNext = IDLE;
      endcase
    end else if (timeout) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bitCnt    <= 3'd0;
      shiftReg  <= 8'h00;
      parityBit <= 1'b0;
      idleCnt   <= '0;
    end else begin
      if (fall) begin
        idleCnt <= '0;
        case (state)
          IDLE:    bitCnt <= 3'd0;
          DATA: begin
            shiftReg[bitCnt] <= psData;
            bitCnt           <= bitCnt + 3'd1;
          end
          PARITY:  parityBit <= psData;
          default: ;
        endcase
      end else if (idleCnt != CNT_W'(TIMEOUT)) begin
        idleCnt <= idleCnt + CNT_W'(1);
      end
    end
  end

  // Prefix bytes only arm the pending flags; a bad frame leaves them alone.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oScanCode    <= 8'h00;
      oScanValid   <= 1'b0;
      oBreak       <= 1'b0;
      oExtended    <= 1'b0;
      oKeyCode     <= 8'h00;
      oParityError <= 1'b0;
      extPend      <= 1'b0;
      brkPend      <= 1'b0;
    end else begin
      oScanValid   <= 1'b0;
      oParityError <= 1'b0;
      if (frameDone) begin
        if (!frameGood) begin
          oParityError <= 1'b1;
        end else if (shiftReg == 8'hE0) begin
          extPend <= 1'b1;
        end else if (shiftReg == 8'hF0) begin
          brkPend <= 1'b1;
        end else begin
          oScanCode  <= shiftReg;
          oBreak     <= brkPend;
          oExtended  <= extPend;
          oScanValid <= 1'b1;
          extPend    <= 1'b0;
          brkPend    <= 1'b0;
          if (!brkPend)                  oKeyCode <= shiftReg;
          else if (shiftReg == oKeyCode) oKeyCode <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver using a shortened PS/2 bit period.
module tb_ps2_scancode_receiver;

  localparam int FLEN = 8;
  localparam int TO   = 300;
  localparam int HALF = 30;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] oScanCode, oKeyCode;
  logic       oScanValid, oBreak, oExtended, oParityError;

  int tests = 0;
  int fails = 0;
  int validCnt = 0;
  int errCnt = 0;
  int v0, e0;

  ps2_scancode_receiver #(.FILTER_LEN(FLEN), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .oScanCode(oScanCode), .oScanValid(oScanValid), .oBreak(oBreak),
    .oExtended(oExtended), .oKeyCode(oKeyCode), .oParityError(oParityError)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oScanValid)   validCnt++;
    if (oParityError) errCnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = bits[i];
      repeat (HALF) @(posedge Clock);
      PS2_CLK = 1'b0;
      repeat (HALF) @(posedge Clock);
      PS2_CLK = 1'b1;
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic parOk, input logic stopOk);
    logic par;
    par = parOk ? ~^b : ^b;
    sendBits({stopOk, par, b, 1'b0}, 11);
    PS2_DATA = 1'b1;
    repeat (2 * HALF) @(posedge Clock);
    #1;
  endtask

  task automatic chkEvent(input string tag, input int dv, input logic [7:0] sc,
                          input logic brk, input logic ext, input logic [7:0] key);
    chk({tag, "_cnt"}, validCnt - v0, dv);
    chk({tag, "_scan"}, oScanCode, sc);
    chk({tag, "_brk"}, oBreak, brk);
    chk({tag, "_ext"}, oExtended, ext);
    chk({tag, "_key"}, oKeyCode, key);
    chk({tag, "_err"}, errCnt - e0, 0);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_scan"}, oScanCode, 8'h00);
    chk({tag, "_vld"}, oScanValid, 1'b0);
    chk({tag, "_brk"}, oBreak, 1'b0);
    chk({tag, "_ext"}, oExtended, 1'b0);
    chk({tag, "_key"}, oKeyCode, 8'h00);
    chk({tag, "_perr"}, oParityError, 1'b0);
  endtask

  task automatic snap();
    v0 = validCnt;
    e0 = errCnt;
  endtask

  initial begin
    repeat (4) @(posedge Clock);
    #1;
    chkAllZero("reset");
    Reset = 1'b0;
    repeat (20) @(posedge Clock);

    // Press A
    snap(); sendFrame(8'h1C, 1, 1);
    chkEvent("pressA", 1, 8'h1C, 0, 0, 8'h1C);

    // Release A
    snap(); sendFrame(8'hF0, 1, 1);
    chk("prefixF0_noValid", validCnt - v0, 0);
    sendFrame(8'h1C, 1, 1);
    chkEvent("releaseA", 1, 8'h1C, 1, 0, 8'h00);

    // Release of a key other than the held one keeps oKeyCode
    snap(); sendFrame(8'h1C, 1, 1); sendFrame(8'hF0, 1, 1); sendFrame(8'h29, 1, 1);
    chkEvent("releaseOther", 2, 8'h29, 1, 0, 8'h1C);

    // Extended make and break
    snap(); sendFrame(8'hE0, 1, 1); sendFrame(8'h75, 1, 1);
    chkEvent("extMake", 1, 8'h75, 0, 1, 8'h75);
    snap(); sendFrame(8'hE0, 1, 1); sendFrame(8'hF0, 1, 1); sendFrame(8'h75, 1, 1);
    chkEvent("extBreak", 1, 8'h75, 1, 1, 8'h00);

    // Bad parity, then bad stop
    sendFrame(8'h1C, 1, 1);
    snap(); sendFrame(8'h29, 0, 1);
    chk("badPar_err", errCnt - e0, 1);
    chk("badPar_noValid", validCnt - v0, 0);
    chk("badPar_key", oKeyCode, 8'h1C);
    snap(); sendFrame(8'h29, 1, 0);
    chk("badStop_err", errCnt - e0, 1);
    chk("badStop_noValid", validCnt - v0, 0);
    chk("badStop_key", oKeyCode, 8'h1C);

    // Bad frame must not consume a pending F0
    snap(); sendFrame(8'hF0, 1, 1); sendFrame(8'h33, 0, 1); sendFrame(8'h1C, 1, 1);
    chk("pendKept_brk", oBreak, 1'b1);
    chk("pendKept_key", oKeyCode, 8'h00);

    // Short clock glitch with data low must not start a frame
    snap();
    PS2_DATA = 1'b0;
    repeat (5) @(posedge Clock);
    PS2_CLK = 1'b0;
    repeat (5) @(posedge Clock);
    PS2_CLK = 1'b1;
    repeat (HALF) @(posedge Clock);
    PS2_DATA = 1'b1;
    repeat (HALF) @(posedge Clock);
    sendFrame(8'h29, 1, 1);
    chkEvent("glitch", 1, 8'h29, 0, 0, 8'h29);

    // Partial frame abandoned after a stall
    snap();
    sendBits({6'b111111, 5'b10110}, 5);
    PS2_DATA = 1'b1;
    repeat (TO + 10) @(posedge Clock);
    sendFrame(8'h1B, 1, 1);
    chkEvent("timeout", 1, 8'h1B, 0, 0, 8'h1B);

    // Reset mid-frame, with a pending F0 that must be cleared
    sendFrame(8'hF0, 1, 1);
    sendBits({3'b111, 8'h1C, 1'b0}, 7);
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chkAllZero("midReset");
    PS2_DATA = 1'b1;
    repeat (HALF) @(posedge Clock);
    Reset = 1'b0;
    repeat (HALF) @(posedge Clock);
    snap(); sendFrame(8'h1B, 1, 1);
    chkEvent("afterReset", 1, 8'h1B, 0, 0, 8'h1B);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
